// File: rtl/bmu_exec.sv
// rtl/bmu_exec.sv - Branch/Memory Unit execution sequencer
// Runs classified BMU ops: memory load/store, stack push/pop, compare, branch, literal load.
module bmu_exec #(
  parameter int                 DATA_W  = 16,
  parameter int                 ADDR_W  = 16,
  parameter logic [ADDR_W-1:0]  SP_INIT = {ADDR_W{1'b1}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [6:0]        OP,
  input  logic              load,
  input  logic              store,
  input  logic              branch,
  input  logic              cmp,
  input  logic              stack,
  input  logic              ldl,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [ADDR_W-1:0] addr,
  output logic              ready,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              zf,
  output logic              nf,
  output logic              br_taken,
  output logic [ADDR_W-1:0] br_target,
  output logic [ADDR_W-1:0] sp,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  typedef enum logic [1:0] {IDLE, MEM, FIN} state_t;

  localparam int EXT_W = (DATA_W > ADDR_W) ? DATA_W : ADDR_W;
  localparam logic [ADDR_W-1:0] SP_ONE = ADDR_W'(1);

  state_t             state;
  logic               rd_op;
  logic               sp_dec;
  logic               sp_inc;
  logic [EXT_W-1:0]   sp_w;
  logic [EXT_W-1:0]   addr_w;

  // Zero-extend (or truncate) address-width values into the data path.
  assign sp_w   = EXT_W'(sp);
  assign addr_w = EXT_W'(addr);
  assign ready  = (state == IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      done      <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      result    <= '0;
      zf        <= 1'b0;
      nf        <= 1'b0;
      br_taken  <= 1'b0;
      br_target <= '0;
      sp        <= SP_INIT;
      rd_op     <= 1'b0;
      sp_dec    <= 1'b0;
      sp_inc    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= FIN;
            done  <= 1'b1;
            if (stack) begin
              case (OP)
                7'd40: result <= sp_w[DATA_W-1:0];
                7'd41: sp <= a[ADDR_W-1:0];
                7'd42: begin
                  state     <= MEM;
                  done      <= 1'b0;
                  mem_req   <= 1'b1;
                  mem_we    <= 1'b1;
                  mem_addr  <= sp - SP_ONE;
                  mem_wdata <= a;
                  rd_op     <= 1'b0;
                  sp_dec    <= 1'b1;
                  sp_inc    <= 1'b0;
                end
                7'd43: begin
                  state    <= MEM;
                  done     <= 1'b0;
                  mem_req  <= 1'b1;
                  mem_we   <= 1'b0;
                  mem_addr <= sp;
                  rd_op    <= 1'b1;
                  sp_dec   <= 1'b0;
                  sp_inc   <= 1'b1;
                end
                default: ;
              endcase
            end else if (load || store) begin
              if (OP == 7'd60 || OP == 7'd61) begin
                state     <= MEM;
                done      <= 1'b0;
                mem_req   <= 1'b1;
                mem_we    <= (OP == 7'd61);
                mem_addr  <= addr;
                mem_wdata <= a;
                rd_op     <= (OP == 7'd60);
                sp_dec    <= 1'b0;
                sp_inc    <= 1'b0;
              end
            end else if (cmp) begin
              if (OP == 7'd50) begin
                zf <= (a == b);
                nf <= ($signed(a) < $signed(b));
              end
            end else if (branch) begin
              // Flags are read as they stand at accept, before any later compare.
              br_target <= addr;
              case (OP)
                7'd51:   br_taken <= zf;
                7'd52:   br_taken <= !zf;
                7'd53:   br_taken <= nf;
                7'd54:   br_taken <= 1'b1;
                default: br_taken <= 1'b0;
              endcase
            end else if (ldl) begin
              if (OP == 7'd64) result <= addr_w[DATA_W-1:0];
            end
          end
        end
        MEM: begin
          if (mem_ack) begin
            state   <= FIN;
            done    <= 1'b1;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (rd_op)  result <= mem_rdata;
            if (sp_dec) sp <= sp - SP_ONE;
            if (sp_inc) sp <= sp + SP_ONE;
          end
        end
        default: begin
          state    <= IDLE;
          done     <= 1'b0;
          br_taken <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/bmu_exec.md
# bmu_exec

Execution sequencer for the Branch/Memory Unit. Consumes the operation-category flags produced by the BMU op classifier, together with the raw opcode and operands, and performs the operation: memory loads/stores over a req/ack bus, stack push/pop with an internal stack pointer, compares into a flag register, branch resolution, and literal loads. It sits between instruction issue and the data-memory port and reports completion with a one-cycle `done` pulse.

## Interface
- DATA_W, 16, operand/data width
- ADDR_W, 16, address and stack-pointer width
- SP_INIT, {ADDR_W{1'b1}}, stack pointer value after reset
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request strobe, accepted only when `ready`=1
- OP  in  7  opcode, sampled at accept
- load, store, branch, cmp, stack, ldl  in  1 each  category flags from the classifier, sampled at accept
- a, b  in  DATA_W  operands, sampled at accept
- addr  in  ADDR_W  address / branch target / literal, sampled at accept
- ready  out  1  high only in IDLE
- done  out  1  one-cycle completion pulse
- result  out  DATA_W  load/pop/literal/SP-read result, holds until next write
- zf, nf  out  1 each  compare flags (equal, signed less-than)
- br_taken  out  1  valid with `done` for branch ops, else 0
- br_target  out  ADDR_W  branch target, valid when `br_taken`=1
- sp  out  ADDR_W  current stack pointer
- mem_req, mem_we  out  1 each  memory request / write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  write data
- mem_rdata  in  DATA_W  read data, valid with `mem_ack`
- mem_ack  in  1  memory completion, one cycle

## Operation
- Decode priority at accept: stack > load/store > cmp > branch > ldl > none (NOP).
- Stack group (`stack`=1): push (store&stack, OP 42): mem write of `a` to sp-1, sp<=sp-1 on ack. Pop (load&stack, OP 43): mem read at sp, result<=rdata, sp<=sp+1 on ack. OP 40: result<=sp zero-extended/truncated to DATA_W. OP 41: sp<=a[ADDR_W-1:0]. OP 44-46: no effect, completes.
- Load (OP 60): read at `addr`, result<=rdata. Store (OP 61): write `a` to `addr`.
- cmp (OP 50): zf<=(a==b), nf<=($signed(a)<$signed(b)); result unchanged.
- Branch: 51 taken if zf, 52 if !zf, 53 if nf, 54 always; uses flags as they stand at accept; br_target<=addr.
- ldl non-stack (OP 64): result<=addr zero-extended to DATA_W, no memory access.
- No flags set: NOP, completes normally.
- SP arithmetic modulo 2^ADDR_W: push at sp=0 gives sp=all-ones; pop at all-ones gives 0.
- FSM: IDLE -> (start, memory op) MEM -> (mem_ack) FIN -> IDLE; IDLE -> (start, non-memory op) FIN -> IDLE. `done` asserted in FIN.

## Timing
- Reset values: state IDLE, ready=1, done=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, result=0, zf=0, nf=0, br_taken=0, br_target=0, sp=SP_INIT.
- Accept at edge T (start&ready). Non-memory op: done=1 during cycle T+1, ready=1 again at T+2.
- Memory op: mem_req/mem_we/mem_addr/mem_wdata registered, valid from T+1, held stable until the edge that samples mem_ack=1; mem_req low the following cycle. done=1 the cycle after ack; result/sp updated at the ack edge, visible with done.
- Minimum memory latency (ack in T+1): done at T+2.
- start while not ready: ignored, no side effects.
- mem_ack while mem_req=0: ignored.
- rst during MEM: next cycle IDLE, mem_req=0, sp=SP_INIT, no done; a late ack is ignored.
- br_taken is 0 in every cycle other than a branch's done cycle.

## Test plan
- Reset, then push a=16'h1234 with ack in 2nd req cycle -> mem_we=1, mem_addr=16'hFFFE, wdata=16'h1234, sp=16'hFFFE at done, done at T+3.
- Pop after that push, rdata=16'h1234 -> mem_addr=16'hFFFE, result=16'h1234, sp=16'hFFFF.
- cmp a=16'hFFFF, b=16'h0001 -> zf=0, nf=1 at T+1; then OP 53 addr=16'h0040 -> br_taken=1, br_target=16'h0040; OP 51 -> br_taken=0.
- OP 41 a=0, then push -> mem_addr=16'hFFFF, sp wraps to 16'hFFFF.
- Load OP 60 addr=16'h0100, assert start again and a stray mem_ack while busy before real ack -> second start ignored; done exactly once; rst asserted mid-MEM -> mem_req=0 next cycle, no done.
- OP 64 addr=16'h00AB -> no mem_req, result=16'h00AB, done at T+1.
